tx_block: RTL and testbench
===========================

TX_BLOCK -- requirements
Module: tx_block

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of data bits per frame (legal range 1-16).
REQ-002 Parameter: TIMER_BITS, default 14, width of bit_period.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: n_rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: tx_start  input  1  request to send one frame; level-sampled in IDLE only.
REQ-006 Port: tx_data  input  DATA_BITS  frame payload, captured on the accepting edge.
REQ-007 Port: bit_period  input  TIMER_BITS  clocks per serial bit, captured on the accepting edge.
REQ-008 Port: abort  input  1  synchronous cancel of the frame in progress.
REQ-009 Port: serial_out  output  1  serial line, registered, idle high.
REQ-010 Port: tx_busy  output  1  registered; high while a frame is on the line.
REQ-011 Port: tx_done  output  1  registered; one-cycle pulse after a frame completes.

Function
REQ-012 Frame format: start bit (0), DATA_BITS data bits LSB first, one stop bit (1).
REQ-013 FSM states: IDLE, START, DATA, STOP; no other reachable states.
REQ-014 IDLE: serial_out=1, tx_busy=0; tx_start=1 and abort=0 at an edge -> START, latch tx_data into a shift register, latch bit_period.
REQ-015 Latched bit_period of 0 is treated as 1; inputs changing after acceptance have no effect on the frame.
REQ-016 Bit timer: counts 1..P (P = latched period) with rollover back to 1; each bit occupies exactly P cycles on serial_out.
REQ-017 START: serial_out=0 for P cycles -> DATA.
REQ-018 DATA: serial_out = shift register LSB; shift right at each bit-timer rollover; after DATA_BITS bits -> STOP.
REQ-019 STOP: serial_out=1 for P cycles -> IDLE.
REQ-020 tx_busy=1 from the first START cycle through the last STOP cycle inclusive: exactly (DATA_BITS+2)*P cycles.
REQ-021 tx_done=1 for exactly one cycle, the first IDLE cycle after STOP; never asserted otherwise.
REQ-022 tx_start during START/DATA/STOP is ignored; no queuing.
REQ-023 Back-to-back: tx_start=1 in the tx_done cycle is accepted; next START begins the following cycle (one idle-high cycle between frames).
REQ-024 abort=1 in START/DATA/STOP -> IDLE next cycle, serial_out=1, tx_busy=0, no tx_done pulse, timer and bit index cleared.
REQ-025 abort and tx_start both high in IDLE: abort wins, frame not accepted.
REQ-026 Bit index counter width = clog2(DATA_BITS+1); no wrap beyond DATA_BITS.

Reset
REQ-027 n_rst low asynchronously forces: state=IDLE, serial_out=1, tx_busy=0, tx_done=0, bit timer=0, bit index=0, shift register=0, latched period=0.
REQ-028 Reset asserted mid-frame takes effect immediately (no clock needed); frame is discarded, no tx_done after release.
REQ-029 First tx_start is accepted on the first rising edge after n_rst deasserts.

Verification
REQ-030 DATA_BITS=8, bit_period=4, tx_data=0xA5, 1-cycle tx_start -> serial_out 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; tx_busy high 40 cycles; tx_done pulses on cycle 41.
REQ-031 bit_period=0 and bit_period=1, tx_data=0x00 -> each bit 1 cycle; tx_busy high 10 cycles; tx_done one cycle.
REQ-032 tx_start held high continuously, bit_period=2, tx_data=0xFF -> frames repeat every 21 cycles with exactly one idle-high cycle (coincident with tx_done) between them.
REQ-033 tx_data/bit_period changed mid-frame, tx_start pulsed mid-frame -> current frame unchanged, no extra frame.
REQ-034 abort asserted on 3rd data bit (bit_period=3) -> serial_out=1, tx_busy=0 next cycle; tx_done never pulses; next tx_start sends a full correct frame.
REQ-035 n_rst pulsed low mid-DATA between clock edges -> serial_out=1, tx_busy=0 immediately; no tx_done after release.

Source files
------------

// File: rtl/tx_block.sv
// Serial frame transmitter: start bit, DATA_BITS data bits LSB first, one stop bit,
// with a per-frame programmable bit period and synchronous abort.
module tx_block #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned TIMER_BITS = 14
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  tx_start,
   input  logic [DATA_BITS-1:0]  tx_data,
   input  logic [TIMER_BITS-1:0] bit_period,
   input  logic                  abort,
   output logic                  serial_out,
   output logic                  tx_busy,
   output logic                  tx_done
);

   localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                state, state_n;
   logic [TIMER_BITS-1:0] timer, timer_n;
   logic [TIMER_BITS-1:0] period, period_n;
   logic [IDX_W-1:0]      idx, idx_n;
   logic [DATA_BITS-1:0]  shreg, shreg_n;
   logic                  serial_n, busy_n, done_n;
   logic                  rollover;
   logic [DATA_BITS-1:0]  shifted;

   assign rollover = (timer == period);
   assign shifted  = shreg >> 1;

   // State and registered outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         timer      <= '0;
         period     <= '0;
         idx        <= '0;
         shreg      <= '0;
         serial_out <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         period     <= period_n;
         idx        <= idx_n;
         shreg      <= shreg_n;
         serial_out <= serial_n;
         tx_busy    <= busy_n;
         tx_done    <= done_n;
      end
   end

   // Next state; outputs are computed for the upcoming cycle so they register cleanly
   always_comb begin
      state_n  = state;
      timer_n  = timer;
      period_n = period;
      idx_n    = idx;
      shreg_n  = shreg;
      serial_n = serial_out;
      busy_n   = tx_busy;
      done_n   = 1'b0;

      case (state)
         IDLE: begin
            serial_n = 1'b1;
            busy_n   = 1'b0;
            if (tx_start && !abort) begin
               state_n  = START;
               timer_n  = TIMER_BITS'(1);
               idx_n    = '0;
               shreg_n  = tx_data;
               period_n = (bit_period == '0) ? TIMER_BITS'(1) : bit_period;
               serial_n = 1'b0;
               busy_n   = 1'b1;
            end
         end
         START: begin
            if (rollover) begin
               state_n  = DATA;
               timer_n  = TIMER_BITS'(1);
               serial_n = shreg[0];
            end else begin
               timer_n = timer + TIMER_BITS'(1);
            end
         end
         DATA: begin
            if (rollover) begin
               timer_n = TIMER_BITS'(1);
               shreg_n = shifted;
               idx_n   = idx + IDX_W'(1);
               if (idx == IDX_W'(DATA_BITS - 1)) begin
                  state_n  = STOP;
                  serial_n = 1'b1;
               end else begin
                  serial_n = shifted[0];
               end
            end else begin
               timer_n = timer + TIMER_BITS'(1);
            end
         end
         STOP: begin
            if (rollover) begin
               state_n  = IDLE;
               timer_n  = '0;
               idx_n    = '0;
               serial_n = 1'b1;
               busy_n   = 1'b0;
               done_n   = 1'b1;
            end else begin
               timer_n = timer + TIMER_BITS'(1);
            end
         end
         default: begin
            state_n  = IDLE;
            timer_n  = '0;
            idx_n    = '0;
            serial_n = 1'b1;
            busy_n   = 1'b0;
         end
      endcase

      // Abort cancels any active frame silently
      if (abort && state != IDLE) begin
         state_n  = IDLE;
         timer_n  = '0;
         idx_n    = '0;
         serial_n = 1'b1;
         busy_n   = 1'b0;
         done_n   = 1'b0;
      end
   end

endmodule

// File: tb/tb_tx_block.sv
// Self-checking bench for tx_block: directed vector table, random frames against a
// frame-level model, plus back-to-back, abort and mid-frame reset sequences.
module tb_tx_block;

   localparam int unsigned DB = 8;
   localparam int unsigned TB = 14;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          tx_start;
   logic [DB-1:0] tx_data;
   logic [TB-1:0] bit_period;
   logic          abort;
   logic          serial_out, tx_busy, tx_done;

   int n_checks = 0;
   int n_fail   = 0;

   tx_block #(.DATA_BITS(DB), .TIMER_BITS(TB)) dut (
      .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
      .bit_period(bit_period), .abort(abort), .serial_out(serial_out),
      .tx_busy(tx_busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DB-1:0] data;
      logic [TB-1:0] period;
      logic [17:0]   frame;  // expected line bits, first bit in position 0
      int            len;    // expected busy cycles
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Frame-level reference: line bits and total busy length from the frame rules
   function automatic logic [17:0] model_frame(input logic [DB-1:0] d);
      return {8'b0, 1'b1, d, 1'b0};
   endfunction

   function automatic int model_len(input logic [TB-1:0] p);
      return (DB + 2) * ((p == '0) ? 1 : int'(p));
   endfunction

   // Send one frame, disturb inputs mid-frame, check every line cycle and the done pulse
   task automatic run_frame(input logic [DB-1:0] d, input logic [TB-1:0] p,
                            input logic [17:0] frame, input int len);
      int peff;
      peff       = len / (DB + 2);
      tx_data    = d;
      bit_period = p;
      tx_start   = 1'b1;
      for (int c = 0; c < len; c++) begin
         @(posedge clk); #1;
         check("serial", 32'(serial_out), 32'(frame[c / peff]));
         check("busy", 32'(tx_busy), 32'd1);
         check("done_early", 32'(tx_done), 32'd0);
         if (c == 0) begin
            tx_start   = 1'b0;
            tx_data    = DB'($urandom);
            bit_period = TB'($urandom_range(0, 7));
         end
         if (c == len / 2)     tx_start = 1'b1;
         if (c == len / 2 + 1) tx_start = 1'b0;
      end
      @(posedge clk); #1;
      check("done_pulse", 32'(tx_done), 32'd1);
      check("busy_end", 32'(tx_busy), 32'd0);
      check("serial_idle", 32'(serial_out), 32'd1);
      @(posedge clk); #1;
      check("done_once", 32'(tx_done), 32'd0);
      check("no_extra_frame", 32'(tx_busy), 32'd0);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 14'd4, 18'h34A, 40};
      vecs[1] = '{8'h00, 14'd0, 18'h200, 10};
      vecs[2] = '{8'h00, 14'd1, 18'h200, 10};
      vecs[3] = '{8'hFF, 14'd2, 18'h3FE, 20};
      vecs[4] = '{8'h3C, 14'd3, 18'h278, 30};
      vecs[5] = '{8'h80, 14'd5, 18'h300, 50};

      n_rst = 1'b0; tx_start = 1'b0; tx_data = '0; bit_period = '0; abort = 1'b0;
      #12;
      check("rst_serial", 32'(serial_out), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;

      // First request right after reset release, then the directed table
      for (int i = 0; i < 6; i++)
         run_frame(vecs[i].data, vecs[i].period, vecs[i].frame, vecs[i].len);

      // Random frames against the model
      for (int i = 0; i < 15; i++) begin
         logic [DB-1:0] d;
         logic [TB-1:0] p;
         d = DB'($urandom);
         p = TB'($urandom_range(0, 6));
         run_frame(d, p, model_frame(d), model_len(p));
      end

      // Continuous tx_start: frames every 21 cycles with one idle/done cycle between
      tx_data = 8'hFF; bit_period = 14'd2; tx_start = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("b2b_serial", 32'(serial_out), 32'((c < 2) ? 0 : 1));
            check("b2b_busy", 32'(tx_busy), 32'd1);
         end
         @(posedge clk); #1;
         check("b2b_done", 32'(tx_done), 32'd1);
         check("b2b_gap_serial", 32'(serial_out), 32'd1);
         check("b2b_gap_busy", 32'(tx_busy), 32'd0);
         if (f == 2) tx_start = 1'b0;
      end
      @(posedge clk); #1;
      check("b2b_stop", 32'(tx_busy), 32'd0);

      // abort and tx_start together in IDLE: abort wins
      tx_start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      check("abort_idle_busy", 32'(tx_busy), 32'd0);
      tx_start = 1'b0; abort = 1'b0;

      // Abort on the third data bit
      tx_data = 8'h5A; bit_period = 14'd3; tx_start = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         tx_start = 1'b0;
         if (c == 9) begin
            check("pre_abort_bit2", 32'(serial_out), 32'd0);
            abort = 1'b1;
         end
      end
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_serial", 32'(serial_out), 32'd1);
      check("abort_busy", 32'(tx_busy), 32'd0);
      begin
         int dones = 0;
         for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (tx_done || tx_busy) dones++;
         end
         check("abort_no_done", 32'(dones), 32'd0);
      end
      run_frame(8'hC3, 14'd3, model_frame(8'hC3), model_len(14'd3));

      // Asynchronous reset mid-DATA, between edges
      tx_data = 8'h00; bit_period = 14'd2; tx_start = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         tx_start = 1'b0;
      end
      check("pre_rst_busy", 32'(tx_busy), 32'd1);
      #2 n_rst = 1'b0;
      #1;
      check("async_rst_serial", 32'(serial_out), 32'd1);
      check("async_rst_busy", 32'(tx_busy), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      begin
         int seen = 0;
         for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (tx_done || tx_busy) seen++;
         end
         check("rst_no_done", 32'(seen), 32'd0);
      end
      run_frame(8'h96, 14'd1, model_frame(8'h96), model_len(14'd1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
